if_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the non-pipelined RISC-V core.

---
 rtl/if_fetch_unit_if.sv | 39 +++
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 tb/tb_if_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/ack channel plus decode-facing outputs.
// Latency: none (wires only).
// Backpressure: imem_req/imem_addr hold until imem_ack; stall holds decode-side outputs.
interface if_fetch_unit_if #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned CNT_WIDTH     = 32
);
  // control-flow inputs from decode/execute
  logic                     stall;
  logic [1:0]               redir_type;
  logic                     redir_en;
  logic                     zero;
  logic [WORD_BITWIDTH-1:0] imm;
  logic [WORD_BITWIDTH-1:0] rs1_val;
  // instruction memory channel
  logic                     imem_req;
  logic [WORD_BITWIDTH-1:0] imem_addr;
  logic                     imem_ack;
  logic [WORD_BITWIDTH-1:0] imem_rdata;
  // decode-facing outputs
  logic                     instr_valid;
  logic [WORD_BITWIDTH-1:0] instr;
  logic [WORD_BITWIDTH-1:0] pc;
  logic [WORD_BITWIDTH-1:0] pc_plus4;
  logic                     trap_misalign;
  logic [CNT_WIDTH-1:0]     retired_cnt;

  // fetch unit side
  modport master (
    input  stall, redir_type, redir_en, zero, imm, rs1_val, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, trap_misalign, retired_cnt
  );

  // memory / decode side
  modport slave (
    output stall, redir_type, redir_en, zero, imm, rs1_val, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, trap_misalign, retired_cnt
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: holds PC, requests imem, latches the word and selects next PC.
// Latency: 2 cycles per instruction with zero-wait ack (REQ then VALID).
// Backpressure: request held with stable address until ack; stall freezes the VALID state.
module if_fetch_unit #(
  parameter int unsigned                 WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0]    RESET_PC      = 32'h0,
  parameter logic [WORD_BITWIDTH-1:0]    TRAP_PC       = 32'h100,
  parameter int unsigned                 IMM_SHIFT     = 1,
  parameter int unsigned                 CNT_WIDTH     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [WORD_BITWIDTH-1:0] r_pc;
  logic [WORD_BITWIDTH-1:0] r_instr;
  logic                     r_trap;
  logic [CNT_WIDTH-1:0]     r_cnt;

  logic                     w_imem_req;
  logic                     w_instr_valid;
  logic                     w_advance;
  logic                     w_taken;
  logic                     w_misalign;
  logic [WORD_BITWIDTH-1:0] w_pc_plus4;
  logic [WORD_BITWIDTH-1:0] w_jalr_sum;
  logic [WORD_BITWIDTH-1:0] w_target;
  logic [WORD_BITWIDTH-1:0] w_next_pc;

  // State register; reset returns to IDLE so a late ack is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs; stall only matters in VALID
  always_comb begin
    w_state_nxt   = r_state;
    w_imem_req    = 1'b0;
    w_instr_valid = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        w_instr_valid = 1'b1;
        if (!bus.stall) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next-PC selection; only consumed in the advancing VALID cycle
  always_comb begin
    w_pc_plus4 = r_pc + WORD_BITWIDTH'(4);
    w_jalr_sum = bus.rs1_val + bus.imm;
    case (bus.redir_type)
      2'b00:   w_taken = bus.redir_en & bus.zero;
      2'b01:   w_taken = bus.redir_en & ~bus.zero;
      default: w_taken = bus.redir_en;
    endcase
    if (bus.redir_type == 2'b11) begin
      w_target = {w_jalr_sum[WORD_BITWIDTH-1:1], 1'b0};
    end else begin
      w_target = r_pc + (bus.imm << IMM_SHIFT);
    end
    w_misalign = w_taken & (w_target[1:0] != 2'b00);
    if (!w_taken) begin
      w_next_pc = w_pc_plus4;
    end else if (w_misalign) begin
      w_next_pc = TRAP_PC;
    end else begin
      w_next_pc = w_target;
    end
  end

  // Datapath: latch instruction on ack, advance PC/counter, one-cycle trap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_trap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_trap <= 1'b0;
      if ((r_state == ST_REQ) && bus.imem_ack) begin
        r_instr <= bus.imem_rdata;
      end
      if (w_advance) begin
        r_pc   <= w_next_pc;
        r_cnt  <= r_cnt + CNT_WIDTH'(1);
        r_trap <= w_misalign;
      end
    end
  end

  assign bus.imem_req      = w_imem_req;
  assign bus.imem_addr     = r_pc;
  assign bus.instr_valid   = w_instr_valid;
  assign bus.instr         = r_instr;
  assign bus.pc            = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.trap_misalign = r_trap;
  assign bus.retired_cnt   = r_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random ack delays, stalls and redirects.
// Latency: checks one instruction per REQ(+wait)/VALID(+stall) sequence.
// Backpressure: ack delay and stall cycles drawn at random.
module tb_if_fetch_unit;
  localparam int unsigned W         = 32;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] TRAP_PC   = 32'h100;
  localparam int unsigned IMM_SHIFT = 1;

  logic clk;
  logic rst_n;

  if_fetch_unit_if #(.WORD_BITWIDTH(W), .CNT_WIDTH(32)) bus ();

  if_fetch_unit #(
    .WORD_BITWIDTH(W),
    .RESET_PC     (RESET_PC),
    .TRAP_PC      (TRAP_PC),
    .IMM_SHIFT    (IMM_SHIFT),
    .CNT_WIDTH    (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_inputs();
    bus.redir_en   = 1'($urandom);
    bus.redir_type = 2'($urandom);
    bus.zero       = 1'($urandom);
    bus.imm        = $urandom;
    bus.rs1_val    = $urandom;
  endtask

  // Expected next PC from the architectural rules
  task automatic model_next(input logic en, input logic [1:0] ty, input logic z,
                            input logic [31:0] im, input logic [31:0] r1,
                            output logic [31:0] npc, output logic trap);
    bit taken;
    taken = en && (ty == 2'd2 || ty == 2'd3 || (ty == 2'd0 && z) || (ty == 2'd1 && !z));
    trap  = 1'b0;
    if (!taken)            npc = m_pc + 32'd4;
    else if (ty == 2'd3)   npc = (r1 + im) & 32'hFFFF_FFFE;
    else                   npc = m_pc + im * (32'd1 << IMM_SHIFT);
    if (taken && (npc % 4 != 0)) begin
      npc  = TRAP_PC;
      trap = 1'b1;
    end
  endtask

  // Runs one instruction; entered and left at posedge+1 in the REQ state
  task automatic run_instr(input int dly, input int nstall, input logic en, input logic [1:0] ty,
                           input logic z, input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] word;
    logic [31:0] npc;
    logic        ntrap;
    word = $urandom;
    for (int k = 0; k < dly; k++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      bus.stall      = 1'($urandom);
      junk_inputs();
      chk("req_wait", 32'(bus.imem_req), 32'd1);
      chk("addr_wait", bus.imem_addr, m_pc);
      chk("valid_wait", 32'(bus.instr_valid), 32'd0);
      step();
    end
    chk("req", 32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr, m_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    bus.stall      = 1'($urandom);
    junk_inputs();
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    chk("valid", 32'(bus.instr_valid), 32'd1);
    chk("req_in_valid", 32'(bus.imem_req), 32'd0);
    chk("instr", bus.instr, word);
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("cnt", bus.retired_cnt, m_cnt);
    chk("trap_clear", 32'(bus.trap_misalign), 32'd0);
    for (int k = 0; k < nstall; k++) begin
      bus.stall = 1'b1;
      junk_inputs();
      step();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_pc", bus.pc, m_pc);
      chk("stall_instr", bus.instr, word);
      chk("stall_cnt", bus.retired_cnt, m_cnt);
    end
    bus.stall      = 1'b0;
    bus.redir_en   = en;
    bus.redir_type = ty;
    bus.zero       = z;
    bus.imm        = im;
    bus.rs1_val    = r1;
    model_next(en, ty, z, im, r1, npc, ntrap);
    step();
    m_pc  = npc;
    m_cnt = m_cnt + 32'd1;
    chk("next_req", 32'(bus.imem_req), 32'd1);
    chk("next_addr", bus.imem_addr, m_pc);
    chk("trap", 32'(bus.trap_misalign), 32'(ntrap));
    chk("cnt_inc", bus.retired_cnt, m_cnt);
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_trap"}, 32'(bus.trap_misalign), 32'd0);
    chk({tag, "_cnt"}, bus.retired_cnt, 32'd0);
    chk({tag, "_pc"}, bus.pc, RESET_PC);
    chk({tag, "_instr"}, bus.instr, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.stall      = 1'b0;
    bus.redir_type = 2'd0;
    bus.redir_en   = 1'b0;
    bus.zero       = 1'b0;
    bus.imm        = '0;
    bus.rs1_val    = '0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // release: one IDLE cycle with no request
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    step();
    m_pc  = RESET_PC;
    m_cnt = 32'd0;

    // sequential fetch 0x0 -> 0x10, one with a 3-cycle ack delay
    run_instr(0, 0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    run_instr(3, 0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    run_instr(0, 0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    run_instr(0, 0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("pc_at_0x10", bus.imem_addr, 32'h10);
    // BEQ taken: 0x10 -> 0x20
    run_instr(0, 0, 1'b1, 2'd0, 1'b1, 32'd8, 32'd0);
    chk("beq_taken", bus.imem_addr, 32'h20);
    // JAL back to 0x10, then BEQ not taken -> 0x14
    run_instr(0, 0, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFF8, 32'd0);
    run_instr(0, 0, 1'b1, 2'd0, 1'b0, 32'd8, 32'd0);
    chk("beq_not_taken", bus.imem_addr, 32'h14);
    // BNE taken with zero=0
    run_instr(1, 0, 1'b1, 2'd1, 1'b0, 32'd6, 32'd0);
    // JALR clears bit 0: 0x101 -> 0x100
    run_instr(0, 0, 1'b1, 2'd3, 1'b0, 32'd0, 32'h101);
    chk("jalr_target", bus.imem_addr, 32'h100);
    // JAL imm=1 -> pc+2 misaligned -> trap
    run_instr(0, 0, 1'b1, 2'd2, 1'b0, 32'd1, 32'd0);
    chk("trap_pc", bus.imem_addr, TRAP_PC);
    // stall 5 cycles in VALID, then exactly one advance
    run_instr(0, 5, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    // wrap: jump to 0xFFFFFFFC then sequential -> 0x0
    run_instr(0, 0, 1'b1, 2'd3, 1'b0, 32'd0, 32'hFFFF_FFFC);
    run_instr(0, 0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      logic [31:0] im;
      if ($urandom_range(0, 3) == 0) im = $urandom;
      else                           im = 32'(int'($urandom_range(0, 63)) - 32);
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom), 2'($urandom), 1'($urandom), im, $urandom);
    end

    // reset asserted mid-request with ack high: outputs drop at once
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    rst_n          = 1'b0;
    #1;
    check_reset_outputs("midreq");
    step();
    chk("late_ack_req", 32'(bus.imem_req), 32'd0);
    chk("late_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("late_ack_instr", bus.instr, 32'd0);
    rst_n        = 1'b1;
    bus.imem_ack = 1'b0;
    #1;
    chk("idle2_req", 32'(bus.imem_req), 32'd0);
    step();
    m_pc  = RESET_PC;
    m_cnt = 32'd0;
    run_instr(2, 1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    run_instr(0, 0, 1'b1, 2'd2, 1'b0, 32'd8, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
